// File: rtl/seq_stage_ctrl.sv
// Stage sequencer for the multi-cycle Y86-64 SEQ core: walks one instruction
// through F/D/E/M/W/PC, owns the condition codes and cnd, tracks stat and
// counts retired instructions.
module seq_stage_ctrl #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       icode,
   input  logic [3:0]       ifun,
   input  logic             instr_valid,
   input  logic             imem_error,
   input  logic             dmem_error,
   input  logic [63:0]      valE,
   input  logic             alu_overflow,
   output logic             f_en,
   output logic             d_en,
   output logic             e_en,
   output logic             m_en,
   output logic             w_en,
   output logic             pc_en,
   output logic             zf,
   output logic             sf,
   output logic             of,
   output logic             cnd,
   output logic [2:0]       stat,
   output logic             busy,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXECUTE,
      S_MEMORY,
      S_WRITEBACK,
      S_PCUPD,
      S_STOP
   } state_t;

   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_HLT = 3'd2;
   localparam logic [2:0] STAT_ADR = 3'd3;
   localparam logic [2:0] STAT_INS = 3'd4;

   localparam logic [3:0] IC_HALT = 4'h0;
   localparam logic [3:0] IC_CMOV = 4'h2;
   localparam logic [3:0] IC_OPQ  = 4'h6;
   localparam logic [3:0] IC_JXX  = 4'h7;

   state_t           state, state_nxt;
   logic             zf_nxt, sf_nxt, of_nxt, cnd_nxt;
   logic [2:0]       stat_nxt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             cond_true;

   // Branch/cmov condition from the current (pre-update) condition codes
   always_comb begin
      cond_true = 1'b0;
      case (ifun)
         4'h0:    cond_true = 1'b1;
         4'h1:    cond_true = (sf ^ of) | zf;
         4'h2:    cond_true = sf ^ of;
         4'h3:    cond_true = zf;
         4'h4:    cond_true = ~zf;
         4'h5:    cond_true = ~(sf ^ of);
         4'h6:    cond_true = ~(sf ^ of) & ~zf;
         default: cond_true = 1'b0;
      endcase
   end

   // Next-state, architectural-state updates and Moore stage enables
   always_comb begin
      state_nxt = state;
      zf_nxt    = zf;
      sf_nxt    = sf;
      of_nxt    = of;
      cnd_nxt   = cnd;
      stat_nxt  = stat;
      cnt_nxt   = instr_count;
      f_en      = 1'b0;
      d_en      = 1'b0;
      e_en      = 1'b0;
      m_en      = 1'b0;
      w_en      = 1'b0;
      pc_en     = 1'b0;
      busy      = (state != S_IDLE) && (state != S_STOP);
      case (state)
         S_IDLE: begin
            if (start) state_nxt = S_FETCH;
         end
         S_FETCH: begin
            f_en = 1'b1;
            if (imem_error) begin
               stat_nxt  = STAT_ADR;
               state_nxt = S_STOP;
            end else if (!instr_valid) begin
               stat_nxt  = STAT_INS;
               state_nxt = S_STOP;
            end else if (icode == IC_HALT) begin
               stat_nxt  = STAT_HLT;
               cnt_nxt   = instr_count + CNT_W'(1);
               state_nxt = S_STOP;
            end else begin
               state_nxt = S_DECODE;
            end
         end
         S_DECODE: begin
            d_en      = 1'b1;
            state_nxt = S_EXECUTE;
         end
         S_EXECUTE: begin
            e_en    = 1'b1;
            cnd_nxt = ((icode == IC_CMOV) || (icode == IC_JXX)) ? cond_true : 1'b0;
            if (icode == IC_OPQ) begin
               zf_nxt = (valE == '0);
               sf_nxt = valE[63];
               of_nxt = alu_overflow;
            end
            state_nxt = S_MEMORY;
         end
         S_MEMORY: begin
            m_en = 1'b1;
            if (dmem_error) begin
               stat_nxt  = STAT_ADR;
               state_nxt = S_STOP;
            end else begin
               state_nxt = S_WRITEBACK;
            end
         end
         S_WRITEBACK: begin
            w_en      = 1'b1;
            state_nxt = S_PCUPD;
         end
         S_PCUPD: begin
            pc_en     = 1'b1;
            cnt_nxt   = instr_count + CNT_W'(1);
            state_nxt = S_FETCH;
         end
         S_STOP: begin
            state_nxt = S_STOP;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // State and architectural registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         zf          <= 1'b1;
         sf          <= 1'b0;
         of          <= 1'b0;
         cnd         <= 1'b0;
         stat        <= STAT_AOK;
         instr_count <= '0;
      end else begin
         state       <= state_nxt;
         zf          <= zf_nxt;
         sf          <= sf_nxt;
         of          <= of_nxt;
         cnd         <= cnd_nxt;
         stat        <= stat_nxt;
         instr_count <= cnt_nxt;
      end
   end

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// Self-checking bench for seq_stage_ctrl: directed scenarios plus randomized
// instruction streams against an instruction-level reference model.
module tb_seq_stage_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  icode = '0;
   logic [3:0]  ifun = '0;
   logic        instr_valid = 1'b1;
   logic        imem_error = 1'b0;
   logic        dmem_error = 1'b0;
   logic [63:0] valE = '0;
   logic        alu_overflow = 1'b0;

   logic        f_en, d_en, e_en, m_en, w_en, pc_en;
   logic        zf, sf, of, cnd, busy;
   logic [2:0]  stat;
   logic [31:0] instr_count;

   logic        b_f, b_d, b_e, b_m, b_w, b_pc, b_zf, b_sf, b_of, b_cnd, b_busy;
   logic [2:0]  b_stat;
   logic [3:0]  b_count;

   int checks = 0;
   int errors = 0;

   // reference model: architectural state at instruction granularity
   logic        m_zf, m_sf, m_of, m_cnd;
   logic [2:0]  m_stat;
   int unsigned m_count;

   seq_stage_ctrl #(.CNT_W(32)) dut (
      .clk(clk), .rst(rst), .start(start), .icode(icode), .ifun(ifun),
      .instr_valid(instr_valid), .imem_error(imem_error), .dmem_error(dmem_error),
      .valE(valE), .alu_overflow(alu_overflow),
      .f_en(f_en), .d_en(d_en), .e_en(e_en), .m_en(m_en), .w_en(w_en), .pc_en(pc_en),
      .zf(zf), .sf(sf), .of(of), .cnd(cnd), .stat(stat), .busy(busy),
      .instr_count(instr_count)
   );

   seq_stage_ctrl #(.CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .start(start), .icode(icode), .ifun(ifun),
      .instr_valid(instr_valid), .imem_error(imem_error), .dmem_error(dmem_error),
      .valE(valE), .alu_overflow(alu_overflow),
      .f_en(b_f), .d_en(b_d), .e_en(b_e), .m_en(b_m), .w_en(b_w), .pc_en(b_pc),
      .zf(b_zf), .sf(b_sf), .of(b_of), .cnd(b_cnd), .stat(b_stat), .busy(b_busy),
      .instr_count(b_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic ref_cond(input logic [3:0] fn, input logic z, input logic s, input logic o);
      logic lt;
      lt = s ^ o; // signed "less than" after a compare
      case (fn)
         4'h0:    return 1'b1;
         4'h1:    return lt | z;
         4'h2:    return lt;
         4'h3:    return z;
         4'h4:    return !z;
         4'h5:    return !lt;
         4'h6:    return !lt && !z;
         default: return 1'b0;
      endcase
   endfunction

   task automatic chk_all(input logic [5:0] en, input logic bsy);
      chk("enables", {f_en, d_en, e_en, m_en, w_en, pc_en}, en);
      chk("busy", busy, bsy);
      chk("cc", {zf, sf, of}, {m_zf, m_sf, m_of});
      chk("cnd", cnd, m_cnd);
      chk("stat", stat, m_stat);
      chk("count32", instr_count, m_count);
      chk("count4", b_count, m_count % 16);
      chk("stat4", b_stat, m_stat);
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // randomize inputs that the current state must ignore
   task automatic junk();
      valE         = {$urandom, $urandom};
      alu_overflow = 1'($urandom);
      dmem_error   = 1'($urandom);
      imem_error   = 1'($urandom);
      instr_valid  = 1'($urandom);
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      start   = 1'b0;
      m_zf    = 1'b1;
      m_sf    = 1'b0;
      m_of    = 1'b0;
      m_cnd   = 1'b0;
      m_stat  = 3'd1;
      m_count = 0;
      #1;
      chk_all(6'b000000, 1'b0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic start_run();
      chk_all(6'b000000, 1'b0);
      start = 1'b1;
      step();
   endtask

   task automatic do_instr(input logic [3:0] ic, input logic [3:0] fn, input logic valid,
                           input logic ierr, input logic derr, input logic [63:0] ve,
                           input logic ovf, output logic stopped);
      stopped = 1'b0;
      // FETCH
      chk_all(6'b100000, 1'b1);
      junk();
      start = 1'($urandom);
      icode = ic; ifun = fn; instr_valid = valid; imem_error = ierr;
      step();
      if (ierr) begin m_stat = 3'd3; stopped = 1'b1; end
      else if (!valid) begin m_stat = 3'd4; stopped = 1'b1; end
      else if (ic == 4'h0) begin m_stat = 3'd2; m_count++; stopped = 1'b1; end
      if (stopped) begin
         chk_all(6'b000000, 1'b0);
         return;
      end
      // DECODE
      chk_all(6'b010000, 1'b1);
      junk(); step();
      // EXECUTE: condition uses the codes as they stood before this instruction
      chk_all(6'b001000, 1'b1);
      junk(); valE = ve; alu_overflow = ovf;
      step();
      m_cnd = ((ic == 4'h2) || (ic == 4'h7)) ? ref_cond(fn, m_zf, m_sf, m_of) : 1'b0;
      if (ic == 4'h6) begin
         m_zf = (ve == 64'd0);
         m_sf = ve[63];
         m_of = ovf;
      end
      // MEMORY
      chk_all(6'b000100, 1'b1);
      junk(); dmem_error = derr;
      step();
      if (derr) begin
         m_stat  = 3'd3;
         stopped = 1'b1;
         chk_all(6'b000000, 1'b0);
         return;
      end
      // WRITEBACK
      chk_all(6'b000010, 1'b1);
      junk(); step();
      // PCUPD
      chk_all(6'b000001, 1'b1);
      junk(); step();
      m_count++;
   endtask

   task automatic stop_hold(input int n);
      for (int i = 0; i < n; i++) begin
         junk();
         start = 1'b1;
         step();
         chk_all(6'b000000, 1'b0);
      end
   endtask

   task automatic nop(output logic st);
      do_instr(4'h1, 4'h0, 1'b1, 1'b0, 1'b0, 64'd5, 1'b0, st);
   endtask

   initial begin
      logic       st;
      logic [6:0] jtbl;
      logic [3:0] ric, rfn;
      logic [63:0] rve;

      @(negedge clk);
      do_reset();
      // idle hold
      for (int i = 0; i < 5; i++) begin
         start = 1'b0;
         step();
         chk_all(6'b000000, 1'b0);
      end

      // sequencing and CC/condition scenarios
      start_run();
      for (int i = 0; i < 3; i++) nop(st);
      chk("three_nops", instr_count, 32'd3);
      do_instr(4'h6, 4'h0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, st);
      chk("cc_zero", {zf, sf, of}, 3'b100);
      do_instr(4'h6, 4'h0, 1'b1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b1, st);
      chk("cc_neg_ovf", {zf, sf, of}, 3'b011);
      do_instr(4'h3, 4'h0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, st);
      chk("cc_hold", {zf, sf, of}, 3'b011);
      do_instr(4'h6, 4'h1, 1'b1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, st);
      jtbl = 7'b0010111; // bit i = expected cnd for ifun i with sf=1,of=0,zf=0
      for (int i = 0; i < 7; i++) begin
         do_instr(4'h7, 4'(i), 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, st);
         chk($sformatf("jxx_ifun%0d", i), cnd, jtbl[i]);
      end
      do_instr(4'h6, 4'h0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, st);
      do_instr(4'h2, 4'h3, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, st);
      chk("cmove_zf", cnd, 1'b1);
      do_instr(4'h5, 4'h0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, st);
      chk("mrmov_cnd", cnd, 1'b0);

      // reset mid-EXECUTE
      do_instr(4'h6, 4'h0, 1'b1, 1'b0, 1'b0, 64'd1, 1'b1, st); // leave CC non-reset
      chk_all(6'b100000, 1'b1);
      icode = 4'h6; instr_valid = 1'b1; imem_error = 1'b0;
      step();
      chk_all(6'b010000, 1'b1);
      step();
      chk_all(6'b001000, 1'b1);
      #2;
      do_reset();
      chk("rst_enables", {f_en, d_en, e_en, m_en, w_en, pc_en, busy}, 7'd0);

      // halt after two nops
      start_run();
      nop(st); nop(st);
      do_instr(4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, st);
      chk("halt_stat", stat, 3'd2);
      chk("halt_count", instr_count, 32'd3);
      stop_hold(4);

      // invalid instruction
      do_reset();
      start_run();
      do_instr(4'h1, 4'h0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, st);
      chk("ins_stat", stat, 3'd4);
      stop_hold(2);

      // imem error wins over invalid
      do_reset();
      start_run();
      do_instr(4'h1, 4'h0, 1'b0, 1'b1, 1'b0, 64'd0, 1'b0, st);
      chk("adr_imem_stat", stat, 3'd3);
      stop_hold(2);

      // dmem error: no retire
      do_reset();
      start_run();
      nop(st);
      do_instr(4'h5, 4'h0, 1'b1, 1'b0, 1'b1, 64'd0, 1'b0, st);
      chk("adr_dmem_stat", stat, 3'd3);
      chk("adr_dmem_count", instr_count, 32'd1);
      stop_hold(3);

      // counter wrap on the 4-bit instance
      do_reset();
      start_run();
      for (int i = 0; i < 17; i++) nop(st);
      chk("wrap4", b_count, 4'd1);
      chk("nowrap32", instr_count, 32'd17);

      // randomized instruction streams
      do_reset();
      start_run();
      for (int i = 0; i < 120; i++) begin
         ric = ($urandom_range(0, 24) == 0) ? 4'h0 : 4'($urandom_range(1, 11));
         rfn = 4'($urandom_range(0, 15));
         rve = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
         do_instr(ric, rfn, $urandom_range(0, 30) != 0, $urandom_range(0, 40) == 0,
                  $urandom_range(0, 40) == 0, rve, 1'($urandom), st);
         if (st) begin
            stop_hold(2);
            do_reset();
            start_run();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_stage_ctrl.md
# seq_stage_ctrl

Multi-cycle stage sequencer for the Y86-64 SEQ core. It steps one instruction at a time through fetch, decode, execute, memory, writeback and PC update, emitting one stage enable per cycle. It owns the condition-code register (ZF/SF/OF) written from the execute-stage ALU result, and evaluates the branch/cmov condition `cnd`. It also tracks the processor status code, stops the core on halt, invalid instruction or address error, and counts retired instructions.

## Interface
Parameters:
- `CNT_W`, 32: width of the retired-instruction counter.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin execution; sampled only in IDLE.
- `icode` in 4: instruction code from fetch; stable from FETCH through PCUPD.
- `ifun` in 4: function code from fetch; stable from FETCH through PCUPD.
- `instr_valid` in 1: fetch decoded a legal icode/ifun; sampled in FETCH.
- `imem_error` in 1: instruction-memory address error; sampled in FETCH.
- `dmem_error` in 1: data-memory address error; sampled in MEMORY.
- `valE` in 64: ALU result; sampled in EXECUTE.
- `alu_overflow` in 1: ALU signed overflow; sampled in EXECUTE.
- `f_en`, `d_en`, `e_en`, `m_en`, `w_en`, `pc_en` out 1 each: stage enables; exactly one is high in the matching state, all low otherwise.
- `zf`, `sf`, `of` out 1 each: condition-code register.
- `cnd` out 1: registered condition result for the current instruction.
- `stat` out 3: status code. 1 = AOK, 2 = HLT, 3 = ADR, 4 = INS.
- `busy` out 1: high when state is neither IDLE nor STOP.
- `instr_count` out CNT_W: number of retired instructions.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, STOP.
- Stage enables and `busy` are Moore decodes of the state register.
- Reset: state IDLE, `zf`=1, `sf`=0, `of`=0, `cnd`=0, `stat`=1 (AOK), `instr_count`=0, all enables 0.
- IDLE: if `start`=1, go to FETCH; otherwise remain in IDLE.
- FETCH exit checks, in priority order:
  - `imem_error`: `stat`←ADR, go to STOP.
  - else `!instr_valid`: `stat`←INS, go to STOP.
  - else `icode`=0 (halt): `stat`←HLT, `instr_count` increments, go to STOP.
  - else go to DECODE.
- DECODE → EXECUTE unconditionally.
- EXECUTE, on exit:
  - `cnd` is loaded with the condition evaluated from the pre-update CC and `ifun`, only when `icode` is 2 (cmovXX) or 7 (jXX). For any other icode `cnd`←0.
  - When `icode`=6 (OPq), the CC register is loaded: `zf`←(`valE`==0), `sf`←`valE`[63], `of`←`alu_overflow`. For any other icode the CC holds.
  - Next state is MEMORY.
- Condition table by `ifun`:
  - 0: 1
  - 1 (le): (sf^of)|zf
  - 2 (l): sf^of
  - 3 (e): zf
  - 4 (ne): !zf
  - 5 (ge): !(sf^of)
  - 6 (g): !(sf^of)&!zf
  - 7–F: 0
- MEMORY: if `dmem_error`, `stat`←ADR and go to STOP (the instruction does not retire). Otherwise go to WRITEBACK.
- WRITEBACK → PCUPD.
- PCUPD: `instr_count` increments (wraps modulo 2^CNT_W), go to FETCH.
- STOP: terminal. `start` is ignored, all enables are 0, and CC/`stat`/count hold until `rst`.
- `stat` stays AOK during normal execution and is written only on entry to STOP.

## Timing
- Each retired non-halt instruction takes 6 cycles, FETCH through PCUPD. Its first FETCH starts the cycle after `start` is sampled in IDLE.
- Halt takes 1 cycle (FETCH), then STOP.
- New CC values are visible the cycle after EXECUTE, i.e. in MEMORY. A following instruction's EXECUTE sees them.
- `cnd` is valid from MEMORY through the next instruction's EXECUTE.
- `rst` asserted in any state, mid-instruction included, forces the reset values immediately and asynchronously. After `rst` deasserts, `start` is required again.
- `imem_error` and `!instr_valid` in the same FETCH cycle: ADR wins.
- Inputs are ignored outside their sampling state.

## Test plan
- Reset/idle: assert `rst` mid-EXECUTE → all enables 0, `zf`=1, `sf`=0, `of`=0, `stat`=1, `instr_count`=0. Hold `start`=0 for 5 cycles → state stays IDLE, `busy`=0.
- Sequencing: `start`, `icode`=1 (nop) repeated for 3 instructions → enables follow f,d,e,m,w,pc, exactly one high per cycle. `instr_count`=3 after 18 busy cycles.
- CC update: OPq (`icode`=6) with `valE`=0, `alu_overflow`=0 → zf=1, sf=0, of=0 in MEMORY. Next OPq with `valE`=64'h8000_0000_0000_0000, `alu_overflow`=1 → zf=0, sf=1, of=1. An `icode`=3 instruction with `valE`=0 → CC unchanged.
- Conditions: with sf=1, of=0, zf=0, run jXX for `ifun` 0–6 → `cnd` = 1,1,1,0,1,0,0. With cmov `icode`=2, `ifun`=3 and zf=1 → `cnd`=1. With `icode`=5 → `cnd`=0.
- Exceptions:
  - halt after 2 nops → `stat`=2, `instr_count`=3, enables stay 0 and `start` is ignored.
  - `instr_valid`=0 → `stat`=4.
  - `imem_error` together with `instr_valid`=0 → `stat`=3.
  - `dmem_error` in MEMORY → `stat`=3, count not incremented, no `w_en`/`pc_en` pulse.
- Counter wrap: CNT_W=4, run 17 nops → `instr_count`=1.
